micro_ucr_hash_ctrl: RTL and testbench
======================================

# micro_ucr_hash_ctrl

Nonce-search controller that sequences one `micro_ucr_hash` core. It captures a 96-bit header and an 8-bit target, then drives the core with `bloque_in = {header, nonce}` for nonce = 0, 1, 2, … It waits a fixed core latency for each nonce, samples `H`, and stops at the first hash whose top byte is below the target or when the nonce range is exhausted. It sits between the host/probador side and the hash core, and owns the core's `fill` and `bloque_in` inputs.

## Interface
Parameters:
- `HASH_LAT`, default 20: cycles from the `fill` cycle to the cycle in which `H` is valid for that block. Must be ≥ 1.
- `MAX_NONCE`, default 32'h0000_FFFF: last nonce tried, inclusive.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a search; sampled only in IDLE.
- `abort`  in  1  cancel the search; return to IDLE.
- `header`  in  96  message part; captured when `start` is accepted.
- `target`  in  8  success when `H[23:16] < target` (unsigned); captured with `header`.
- `H`  in  24  hash output from the core.
- `fill`  out  1  one-cycle load strobe to the core.
- `bloque_in`  out  128  `{header_q, nonce}` to the core.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  one-cycle pulse when a search ends.
- `found`  out  1  valid with `done`, held until the next accepted `start`.
- `nonce_out`  out  32  winning nonce, or MAX_NONCE on exhaustion.
- `hash_out`  out  24  `H` sampled for `nonce_out`.

## Operation
- FSM states: IDLE, LOAD, WAIT, CHECK, DONE.
- IDLE:
  - If `start` is high, capture `header` and `target`, set nonce to 0, clear `found`, and go to LOAD.
- LOAD (1 cycle):
  - `fill` = 1. `bloque_in` carries the current nonce.
  - Clear the wait counter and go to WAIT.
- WAIT (HASH_LAT cycles):
  - Increment the counter each cycle. `bloque_in` is held stable.
  - On the last WAIT cycle, register `H` into `hash_q` and go to CHECK.
- CHECK (1 cycle):
  - If `hash_q[23:16] < target_q`: `found` = 1, `nonce_out` = nonce, `hash_out` = `hash_q`, go to DONE.
  - Else if nonce == MAX_NONCE: `found` = 0, `nonce_out` = MAX_NONCE, `hash_out` = `hash_q`, go to DONE.
  - Else: nonce = nonce + 1, go to LOAD.
- DONE (1 cycle):
  - `done` = 1, then go to IDLE.
- Arithmetic and ranges:
  - The nonce counter is 32 bits.
  - The nonce is never incremented past MAX_NONCE, so no wrap occurs even when MAX_NONCE = 32'hFFFF_FFFF.
  - The wait counter is `$clog2(HASH_LAT+1)` bits.
- `abort`:
  - From any state, the next state is IDLE.
  - `fill` is low in the following cycle. No `done` pulse.
  - `found`, `nonce_out` and `hash_out` keep their previous values.
  - `abort` and `start` high together in IDLE: `abort` wins and the search does not start.
- `start` while not in IDLE is ignored. The captured `header` and `target` are unaffected.
- `start` high in DONE is ignored. A new search needs `start` in IDLE, at the earliest the cycle after `done`.
- Constant target values:
  - `target` = 0: no hash can match, so the search always exhausts.
  - `target` = 8'hFF: every top byte except 0xFF matches.

## Timing
- Reset (synchronous) forces the following on the next rising edge, including mid-search:
  - state IDLE, nonce 0, wait counter 0;
  - `fill`, `busy`, `done`, `found` = 0;
  - `bloque_in`, `nonce_out`, `hash_out`, `hash_q`, `header_q`, `target_q` = 0.
- Per-nonce period: HASH_LAT + 2 cycles (LOAD + WAIT + CHECK).
- With `start` sampled at edge e0, the search ends at nonce index k:
  - `busy` is high from cycle 1 through cycle (k+1)(HASH_LAT+2);
  - `done` is high in cycle (k+1)(HASH_LAT+2)+1.
- `fill` is high exactly one cycle per nonce, spaced HASH_LAT+2 cycles apart.
- `bloque_in` changes only on the edge into LOAD.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use HASH_LAT = 4 and a stub core. The stub returns `H = {8'hFF - bloque_in[7:0], 16'h1234}`, valid HASH_LAT cycles after `fill`.

- Hit: `header` = 96'hA5…A5, `target` = 8'hF0, one `start` pulse → `done` at cycle 103; `found` = 1, `nonce_out` = 32'h10, `hash_out` = 24'hEF1234. Exactly 17 `fill` pulses, 6 cycles apart; `bloque_in[127:32]` = 96'hA5…A5 throughout.
- Exhaust: MAX_NONCE = 32'h7, `target` = 8'h00 → `done` at cycle 8·6+1 = 49; `found` = 0, `nonce_out` = 7, `hash_out` = 24'hF81234.
- Abort: `abort` asserted at cycle 20 of the hit search → IDLE at the next edge; no `done`, no further `fill`; `found`, `nonce_out`, `hash_out` unchanged.
- Reset mid-search: `reset` = 1 for 1 cycle at cycle 30 → every output 0 at the next edge. A new `start` then reproduces the hit result exactly.
- Ignored `start`: `start` is pulsed every cycle during a search, and `header`/`target` are changed to new values after acceptance → result identical to the hit case. `start` together with `abort` in IDLE → `busy` stays 0.

Source files
------------

// File: rtl/micro_ucr_hash_ctrl_if.sv
// Bundle of host-side and hash-core-side signals for the nonce-search controller.
// Purely combinational wiring: no storage, no added latency.
// The interface has no flow control of its own. The controller drives busy/done, and the core drives H.
interface micro_ucr_hash_ctrl_if;
  // host / probador side
  logic         start;
  logic         abort;
  logic [95:0]  header;
  logic [7:0]   target;
  logic         busy;
  logic         done;
  logic         found;
  logic [31:0]  nonce_out;
  logic [23:0]  hash_out;
  // hash core side
  logic [23:0]  H;
  logic         fill;
  logic [127:0] bloque_in;

  // The controller sits on this side.
  modport slave (
    input  start, abort, header, target, H,
    output fill, bloque_in, busy, done, found, nonce_out, hash_out
  );

  // The host and the hash core together sit on this side.
  modport master (
    output start, abort, header, target, H,
    input  fill, bloque_in, busy, done, found, nonce_out, hash_out
  );
endinterface

// File: rtl/micro_ucr_hash_ctrl.sv
// Nonce-search sequencer for one micro_ucr_hash core: tries nonce 0..MAX_NONCE until H[23:16] < target.
// Latency: HASH_LAT+2 cycles per nonce. done fires one cycle after the CHECK of the final nonce.
// No backpressure: start is taken only in IDLE, and abort returns to IDLE from any state.
module micro_ucr_hash_ctrl #(
  parameter int unsigned HASH_LAT  = 20,
  parameter logic [31:0] MAX_NONCE = 32'h0000_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  micro_ucr_hash_ctrl_if.slave  bus
);

  localparam int unsigned        CNT_W    = $clog2(HASH_LAT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HASH_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  state_e         state_q,     state_d;
  logic [31:0]    nonce_q,     nonce_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [95:0]    header_q,    header_d;
  logic [7:0]     target_q,    target_d;
  logic [23:0]    hash_q,      hash_d;
  logic           found_q,     found_d;
  logic [31:0]    nonce_out_q, nonce_out_d;
  logic [23:0]    hash_out_q,  hash_out_d;
  logic [127:0]   bloque_q,    bloque_d;
  logic           fill_q,      fill_d;
  logic           busy_q,      busy_d;
  logic           done_q,      done_d;

  // Next-state and datapath decisions. Abort overrides everything and leaves the results untouched.
  always_comb begin
    state_d     = state_q;
    nonce_d     = nonce_q;
    cnt_d       = cnt_q;
    header_d    = header_q;
    target_d    = target_q;
    hash_d      = hash_q;
    found_d     = found_q;
    nonce_out_d = nonce_out_q;
    hash_out_d  = hash_out_q;

    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            header_d = bus.header;
            target_d = bus.target;
            nonce_d  = '0;
            found_d  = 1'b0;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            hash_d  = bus.H;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (hash_q[23:16] < target_q) begin
            found_d     = 1'b1;
            nonce_out_d = nonce_q;
            hash_out_d  = hash_q;
            state_d     = S_DONE;
          end else if (nonce_q == MAX_NONCE) begin
            // The range is exhausted. Stopping here means the nonce never wraps.
            found_d     = 1'b0;
            nonce_out_d = MAX_NONCE;
            hash_out_d  = hash_q;
            state_d     = S_DONE;
          end else begin
            nonce_d = nonce_q + 32'd1;
            state_d = S_LOAD;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they come straight from flops, aligned with the state.
  always_comb begin
    bloque_d = bloque_q;
    if (state_d == S_LOAD) begin
      bloque_d = {header_d, nonce_d};
    end
    fill_d = (state_d == S_LOAD);
    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  // State and output registers, with a synchronous clear of everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      nonce_q     <= '0;
      cnt_q       <= '0;
      header_q    <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      found_q     <= 1'b0;
      nonce_out_q <= '0;
      hash_out_q  <= '0;
      bloque_q    <= '0;
      fill_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nonce_q     <= nonce_d;
      cnt_q       <= cnt_d;
      header_q    <= header_d;
      target_q    <= target_d;
      hash_q      <= hash_d;
      found_q     <= found_d;
      nonce_out_q <= nonce_out_d;
      hash_out_q  <= hash_out_d;
      bloque_q    <= bloque_d;
      fill_q      <= fill_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.fill      = fill_q;
  assign bus.bloque_in = bloque_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.found     = found_q;
  assign bus.nonce_out = nonce_out_q;
  assign bus.hash_out  = hash_out_q;

endmodule

// File: tb/tb_micro_ucr_hash_ctrl.sv
// Bench for micro_ucr_hash_ctrl: two instances (full range / MAX_NONCE=7), each with a stub core.
// Stub core: H = {FF - nonce[7:0], 1234}, valid HASH_LAT cycles after fill, zero otherwise.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_micro_ucr_hash_ctrl;

  localparam int LAT    = 4;
  localparam int PERIOD = LAT + 2;
  localparam int BUDGET = 2000;
  localparam logic [31:0] MAXA = 32'h0000_FFFF;
  localparam logic [31:0] MAXB = 32'h0000_0007;
  localparam logic [95:0] HDR_A5 = {12{8'hA5}};

  typedef struct {
    bit          sel;     // 0: instance A, 1: instance B
    logic [95:0] hdr;
    logic [7:0]  tgt;
    bit          hammer;  // pulse start and scramble header/target during the search
    bit          f;
    logic [31:0] n;
    logic [23:0] h;
    int          dc;      // cycle of done, counting from the start edge
  } vec_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic st, ab, cur;
  logic [95:0] header;
  logic [7:0]  target;
  int checks = 0;
  int errors = 0;

  micro_ucr_hash_ctrl_if ifa ();
  micro_ucr_hash_ctrl_if ifb ();

  micro_ucr_hash_ctrl #(.HASH_LAT(LAT), .MAX_NONCE(MAXA)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  micro_ucr_hash_ctrl #(.HASH_LAT(LAT), .MAX_NONCE(MAXB)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  always #5 clk = ~clk;

  assign ifa.start  = st & ~cur;
  assign ifb.start  = st & cur;
  assign ifa.abort  = ab & ~cur;
  assign ifb.abort  = ab & cur;
  assign ifa.header = header;
  assign ifb.header = header;
  assign ifa.target = target;
  assign ifb.target = target;

  // stub cores: delay line of LAT stages
  logic [LAT-1:0]   pa_v = '0, pb_v = '0;
  logic [8*LAT-1:0] pa_d = '0, pb_d = '0;
  always @(posedge clk) begin
    pa_v <= {pa_v[LAT-2:0], ifa.fill};
    pa_d <= {pa_d[8*LAT-9:0], ifa.bloque_in[7:0]};
    pb_v <= {pb_v[LAT-2:0], ifb.fill};
    pb_d <= {pb_d[8*LAT-9:0], ifb.bloque_in[7:0]};
  end
  assign ifa.H = pa_v[LAT-1] ? {8'hFF - pa_d[8*LAT-1 -: 8], 16'h1234} : 24'h0;
  assign ifb.H = pb_v[LAT-1] ? {8'hFF - pb_d[8*LAT-1 -: 8], 16'h1234} : 24'h0;

  // view of the instance selected by cur
  logic         m_fill, m_busy, m_done, m_found;
  logic [31:0]  m_nonce;
  logic [23:0]  m_hash;
  logic [127:0] m_bloque;
  assign m_fill   = cur ? ifb.fill      : ifa.fill;
  assign m_busy   = cur ? ifb.busy      : ifa.busy;
  assign m_done   = cur ? ifb.done      : ifa.done;
  assign m_found  = cur ? ifb.found     : ifa.found;
  assign m_nonce  = cur ? ifb.nonce_out : ifa.nonce_out;
  assign m_hash   = cur ? ifb.hash_out  : ifa.hash_out;
  assign m_bloque = cur ? ifb.bloque_in : ifa.bloque_in;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: scan the nonce range with the stub-core hash and stop at the first hit.
  function automatic vec_t model(input bit sel, input logic [95:0] hdr, input logic [7:0] tgt);
    vec_t r;
    logic [31:0] maxn;
    logic [7:0]  top;
    maxn = sel ? MAXB : MAXA;
    r.sel = sel; r.hdr = hdr; r.tgt = tgt; r.hammer = 1'b0;
    r.f = 1'b0; r.n = '0; r.h = '0;
    for (longint i = 0; i <= longint'(maxn); i++) begin
      top = 8'hFF - 8'(i);
      r.h = {top, 16'h1234};
      r.n = 32'(i);
      if (top < tgt) begin
        r.f = 1'b1;
        break;
      end
    end
    r.dc = (int'(r.n) + 1) * PERIOD + 1;
    return r;
  endfunction

  // One complete search: start pulse, per-cycle protocol monitoring, then the result.
  task automatic run_search(input vec_t v, input string tag);
    int cyc, done_cyc, fills, last_fill, gap_err, busy_err, seq_err;
    @(negedge clk);
    cur = v.sel; header = v.hdr; target = v.tgt; st = 1'b1;
    @(negedge clk);
    cyc = 1; done_cyc = -1; fills = 0; last_fill = 0;
    gap_err = 0; busy_err = 0; seq_err = 0;
    while (cyc <= BUDGET) begin
      if (m_fill) begin
        if (fills > 0 && (cyc - last_fill) != PERIOD) gap_err++;
        if (m_bloque[31:0] !== 32'(fills)) seq_err++;
        fills++;
        last_fill = cyc;
      end
      if (m_bloque[127:32] !== v.hdr) seq_err++;
      if (m_done) begin
        done_cyc = cyc;
        break;
      end
      if (m_busy !== 1'b1) busy_err++;
      if (v.hammer) begin
        st = 1'b1;
        header = {$urandom, $urandom, $urandom};
        target = 8'($urandom);
      end else begin
        st = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    st = 1'b0;
    check({tag, " done cycle"}, 128'(done_cyc), 128'(v.dc));
    check({tag, " found"}, 128'(m_found), 128'(v.f));
    check({tag, " nonce_out"}, 128'(m_nonce), 128'(v.n));
    check({tag, " hash_out"}, 128'(m_hash), 128'(v.h));
    check({tag, " fill count"}, 128'(fills), 128'(v.n) + 128'd1);
    check({tag, " fill spacing/nonce/header"}, 128'(gap_err + seq_err), 128'd0);
    check({tag, " busy while searching"}, 128'(busy_err), 128'd0);
    check({tag, " busy low with done"}, 128'(m_busy), 128'd0);
    @(negedge clk);
    check({tag, " done one cycle"}, 128'({m_done, m_busy}), 128'd0);
  endtask

  vec_t vecs [6];
  vec_t rv;

  initial begin
    int fills, dones, busys;
    vecs[0] = '{0, HDR_A5, 8'hF0, 0, 1, 32'h10, 24'hEF1234, 103};
    vecs[1] = '{1, 96'h0123_4567_89AB_CDEF_0011_2233, 8'h00, 0, 0, 32'h7, 24'hF81234, 49};
    vecs[2] = '{1, 96'hDEAD_BEEF_0000_FFFF_1357_9BDF, 8'hFF, 0, 1, 32'h1, 24'hFE1234, 13};
    vecs[3] = '{0, 96'h0F0F_0F0F_F0F0_F0F0_5A5A_5A5A, 8'h80, 0, 1, 32'h80, 24'h7F1234, 775};
    vecs[4] = '{1, 96'h1111_2222_3333_4444_5555_6666, 8'hF9, 0, 1, 32'h7, 24'hF81234, 49};
    vecs[5] = '{0, HDR_A5, 8'hF0, 1, 1, 32'h10, 24'hEF1234, 103};

    st = 1'b0; ab = 1'b0; cur = 1'b0; header = '0; target = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    check("reset A flags", 128'({ifa.fill, ifa.busy, ifa.done, ifa.found}), 128'd0);
    check("reset A data", {ifa.nonce_out, ifa.hash_out, ifa.bloque_in[71:0]}, 128'd0);
    check("reset B flags", 128'({ifb.fill, ifb.busy, ifb.done, ifb.found}), 128'd0);
    check("reset bloque_in", ifa.bloque_in | ifb.bloque_in, 128'd0);

    for (int i = 0; i < 6; i++) run_search(vecs[i], $sformatf("vec%0d", i));

    // abort at cycle 20 of the hit search
    @(negedge clk);
    cur = 1'b0; header = HDR_A5; target = 8'hF0; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (19) @(negedge clk);
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    check("abort busy/fill next cycle", 128'({m_busy, m_fill}), 128'd0);
    fills = 0; dones = 0; busys = 0;
    repeat (40) begin
      @(negedge clk);
      fills += int'(m_fill); dones += int'(m_done); busys += int'(m_busy);
    end
    check("abort no fill/done/busy after", 128'(fills + dones + busys), 128'd0);
    check("abort found", 128'(m_found), 128'd0);
    check("abort nonce_out kept", 128'(m_nonce), 128'h10);
    check("abort hash_out kept", 128'(m_hash), 128'hEF1234);

    // synchronous reset at cycle 30 of a search
    @(negedge clk);
    cur = 1'b0; header = HDR_A5; target = 8'hF0; st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (29) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("midreset flags", 128'({m_fill, m_busy, m_done, m_found}), 128'd0);
    check("midreset nonce_out", 128'(m_nonce), 128'd0);
    check("midreset hash_out", 128'(m_hash), 128'd0);
    check("midreset bloque_in", m_bloque, 128'd0);
    run_search(vecs[0], "hit after reset");

    // start together with abort in IDLE
    @(negedge clk);
    cur = 1'b0; st = 1'b1; ab = 1'b1;
    @(negedge clk);
    st = 1'b0; ab = 1'b0;
    check("start+abort busy", 128'({m_busy, m_fill}), 128'd0);
    @(negedge clk);
    check("start+abort still idle", 128'({m_busy, m_fill}), 128'd0);

    // randomized searches against the reference scan
    for (int i = 0; i < 6; i++) begin
      rv = model(1'b0, {$urandom, $urandom, $urandom}, 8'($urandom_range(1, 255)));
      run_search(rv, $sformatf("randA%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      rv = model(1'b1, {$urandom, $urandom, $urandom}, 8'($urandom_range(0, 255)));
      run_search(rv, $sformatf("randB%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
